// File: rtl/kbdport_if.sv
// Keyboard port bus: CPU register access, keyboard decoder push and the
// interrupt acknowledge path grouped between the host side and kbdport.
interface kbdport_if #(
    parameter int DEPTH  = 4,
    parameter int CODE_W = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              regwr;
    logic              regrd;
    logic              addr;
    logic [15:0]       data_i;
    logic [15:0]       data_o;
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_ar2;
    logic              iako;
    logic              virq;
    logic [15:0]       vector_o;
    logic [LVL_W-1:0]  level_o;

    // Host side: CPU bus plus keyboard decoder
    modport master (
        output regwr, regrd, addr, data_i, key_valid, key_code, key_ar2, iako,
        input  data_o, virq, vector_o, level_o
    );

    // Keyboard port block
    modport slave (
        input  regwr, regrd, addr, data_i, key_valid, key_code, key_ar2, iako,
        output data_o, virq, vector_o, level_o
    );
endinterface

// File: rtl/kbdport.sv
// Keyboard port: a small FIFO of {ar2, code} entries, with a state register,
// a data register that pops on read, and a vectored interrupt whose vector
// is frozen for the whole interrupt acknowledge.
module kbdport #(
    parameter int          DEPTH    = 4,
    parameter int          CODE_W   = 8,
    parameter logic [15:0] VEC_NORM = 16'o000060,
    parameter logic [15:0] VEC_AR2  = 16'o000274
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      ce,
    kbdport_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = CODE_W + 1;

    typedef logic [EW-1:0] entry_t;   // {ar2, code}

    // Pointers carry one extra bit so full and empty can be told apart
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    entry_t        mem_q [DEPTH];
    entry_t        last_q, last_d;
    logic          ovf_q, ovf_d;
    logic          intdis_q, intdis_d;
    logic          held_q, held_d;
    logic [15:0]   vhold_q, vhold_d;

    logic          empty, full;
    logic          push_req, pop_req, push_ok, pop_ok;
    logic          st_rd, st_wr, ovf_set;
    entry_t        head, view;
    logic [15:0]   vec_live;
    logic [15:0]   rdata;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head  = mem_q[rptr_q[AW-1:0]];

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when it coincides with a data read.
    assign pop_req  = ce & bus.regrd & bus.addr;
    assign pop_ok   = pop_req & ~empty;
    assign push_req = ce & bus.key_valid;
    assign push_ok  = push_req & (~full | pop_ok);
    assign ovf_set  = push_req & full & ~pop_ok;
    assign st_rd    = ce & bus.regrd & ~bus.addr;
    assign st_wr    = ce & bus.regwr & ~bus.addr;

    // Data register shows the head while anything is queued, otherwise the
    // last popped entry so a repeated read returns the same key.
    assign view = empty ? last_q : head;

    // Combinational register read mux
    always_comb begin
        rdata = '0;
        if (!bus.addr) begin
            rdata[7] = ~empty;
            rdata[6] = intdis_q;
            rdata[5] = ovf_q;
        end else begin
            rdata[CODE_W-1:0] = view[CODE_W-1:0];
            rdata[15]         = view[CODE_W];
        end
    end

    assign vec_live = (!empty && head[CODE_W]) ? VEC_AR2 : VEC_NORM;

    assign bus.data_o   = rdata;
    assign bus.virq     = ~empty & ~intdis_q;
    assign bus.level_o  = wptr_q - rptr_q;
    // Once captured, the held vector masks any push/pop during acknowledge
    assign bus.vector_o = (bus.iako && held_q) ? vhold_q : vec_live;

    // Next-state for pointers, flags and the acknowledge vector hold
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        last_d   = last_q;
        ovf_d    = ovf_q;
        intdis_d = intdis_q;
        held_d   = held_q;
        vhold_d  = vhold_q;

        if (push_ok) wptr_d = wptr_q + PW'(1);
        if (pop_ok) begin
            rptr_d = rptr_q + PW'(1);
            last_d = head;
        end

        // A same-cycle overflow beats the clear-on-read
        if (ovf_set)    ovf_d = 1'b1;
        else if (st_rd) ovf_d = 1'b0;

        if (st_wr) intdis_d = bus.data_i[6];

        if (ce) begin
            if (bus.iako && !held_q) begin
                held_d  = 1'b1;
                vhold_d = vec_live;
            end else if (!bus.iako) begin
                held_d  = 1'b0;
            end
        end
    end

    // Control and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            last_q   <= '0;
            ovf_q    <= 1'b0;
            intdis_q <= 1'b0;
            held_q   <= 1'b0;
            vhold_q  <= VEC_NORM;
        end else if (ce) begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            intdis_q <= intdis_d;
            held_q   <= held_d;
            vhold_q  <= vhold_d;
        end
    end

    // FIFO storage; cleared on reset so stale keys never reappear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wptr_q[AW-1:0]] <= {bus.key_ar2, bus.key_code};
        end
    end
endmodule

// File: tb/tb_kbdport.sv
// Scoreboard bench for kbdport: expected keys are queued on push and
// compared when popped through the data register.
module tb_kbdport;
    localparam int DEPTH  = 4;
    localparam int CODE_W = 8;
    localparam logic [15:0] VN = 16'o000060;
    localparam logic [15:0] VA = 16'o000274;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ce = 1'b0;

    kbdport_if #(.DEPTH(DEPTH), .CODE_W(CODE_W)) bus ();

    kbdport #(.DEPTH(DEPTH), .CODE_W(CODE_W), .VEC_NORM(VN), .VEC_AR2(VA)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [8:0] sb_q [$];
    logic [8:0] last_m;
    logic       ovf_m, intdis_m;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [15:0] data_exp();
        logic [8:0] e;
        e = (sb_q.size() != 0) ? sb_q[0] : last_m;
        return {e[8], 7'b0, e[7:0]};
    endfunction

    function automatic logic [15:0] state_exp();
        return {8'b0, sb_q.size() != 0, intdis_m, ovf_m, 5'b0};
    endfunction

    function automatic logic [15:0] vec_exp();
        return (sb_q.size() != 0 && sb_q[0][8]) ? VA : VN;
    endfunction

    task automatic model_reset();
        sb_q.delete();
        last_m   = '0;
        ovf_m    = 1'b0;
        intdis_m = 1'b0;
    endtask

    // One ce cycle with optional push and/or data-register read
    task automatic cycle(input bit push, input logic [8:0] e, input bit pop);
        bit pop_ok, push_ok;
        @(negedge clk);
        bus.key_valid = push;
        bus.key_code  = e[7:0];
        bus.key_ar2   = e[8];
        bus.regrd     = pop;
        bus.addr      = pop;
        #1;
        if (pop) chk("data", bus.data_o, data_exp());
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        bus.regrd     = 1'b0;
        bus.addr      = 1'b0;
        pop_ok  = pop && sb_q.size() != 0;
        push_ok = push && (sb_q.size() < DEPTH || pop_ok);
        if (push && !push_ok) ovf_m = 1'b1;
        if (pop_ok) last_m = sb_q.pop_front();
        if (push_ok) sb_q.push_back(e);
        chk("level", 16'(bus.level_o), 16'(sb_q.size()));
        chk("virq", 16'(bus.virq), 16'(sb_q.size() != 0 && !intdis_m));
    endtask

    task automatic push(input logic [8:0] e);
        cycle(1'b1, e, 1'b0);
    endtask

    task automatic pop();
        cycle(1'b0, 9'h0, 1'b1);
    endtask

    task automatic st_read(output logic [15:0] v);
        @(negedge clk);
        bus.regrd = 1'b1;
        bus.addr  = 1'b0;
        #1;
        v = bus.data_o;
        chk("state", v, state_exp());
        @(posedge clk);
        #1;
        bus.regrd = 1'b0;
        ovf_m = 1'b0;
    endtask

    task automatic st_write(input logic [15:0] v);
        @(negedge clk);
        bus.regwr  = 1'b1;
        bus.addr   = 1'b0;
        bus.data_i = v;
        @(posedge clk);
        #1;
        bus.regwr = 1'b0;
        intdis_m  = v[6];
    endtask

    initial begin
        logic [15:0] sv;
        bus.regwr = 1'b0; bus.regrd = 1'b0; bus.addr = 1'b0; bus.data_i = '0;
        bus.key_valid = 1'b0; bus.key_code = '0; bus.key_ar2 = 1'b0; bus.iako = 1'b0;
        model_reset();

        // Reset state
        #2;
        chk("rst level", 16'(bus.level_o), 16'd0);
        chk("rst virq", 16'(bus.virq), 16'd0);
        chk("rst state", bus.data_o, 16'o0);
        chk("rst vector", bus.vector_o, VN);
        @(negedge clk);
        reset_n = 1'b1;
        ce = 1'b1;

        // Single key round trip
        push(9'h041);
        st_read(sv);
        chk("one state", sv, 16'o000200);
        chk("one vector", bus.vector_o, 16'o060);
        pop();
        chk("one level", 16'(bus.level_o), 16'd0);
        chk("one virq", 16'(bus.virq), 16'd0);
        cycle(1'b0, 9'h0, 1'b1);   // empty read returns last-read value

        // Overflow: DEPTH+1 pushes, last one dropped
        for (int i = 0; i <= DEPTH; i++) push(9'(8'h10 + i));
        chk("ovf level", 16'(bus.level_o), 16'(DEPTH));
        st_read(sv);
        chk("ovf state", sv, 16'o000240);
        st_read(sv);
        chk("ovf cleared", sv, 16'o000200);
        for (int i = 0; i < DEPTH; i++) pop();

        // Full FIFO with simultaneous push and pop across pointer wrap
        for (int i = 0; i < DEPTH; i++) push(9'(8'h20 + i));
        for (int i = 0; i < 6; i++) cycle(1'b1, 9'(8'h60 + i), 1'b1);
        chk("full pp level", 16'(bus.level_o), 16'(DEPTH));
        st_read(sv);
        chk("full pp state", sv, 16'o000200);
        for (int i = 0; i < DEPTH; i++) pop();

        // Interrupt disable and AR2 vector
        st_write(16'o000100);
        push(9'h122);
        chk("intdis virq", 16'(bus.virq), 16'd0);
        st_read(sv);
        chk("intdis state", sv, 16'o000300);
        st_write(16'o000000);
        chk("inten virq", 16'(bus.virq), 16'd1);
        chk("ar2 vector", bus.vector_o, 16'o274);
        pop();
        chk("ar2 bit15", 16'(last_m[8]), 16'd1);

        // Vector frozen during acknowledge
        push(9'h133);
        push(9'h034);
        @(negedge clk);
        bus.iako = 1'b1;
        #1;
        chk("iako vec0", bus.vector_o, VA);
        pop();
        chk("iako vec pop", bus.vector_o, VA);
        push(9'h035);
        chk("iako vec push", bus.vector_o, VA);
        @(negedge clk);
        bus.iako = 1'b0;
        #1;
        chk("iako release", bus.vector_o, vec_exp());

        // Reset in the middle of a push and acknowledge
        @(negedge clk);
        bus.iako = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_code = 8'h77;
        bus.key_ar2 = 1'b1;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("mid rst level", 16'(bus.level_o), 16'd0);
        chk("mid rst virq", 16'(bus.virq), 16'd0);
        chk("mid rst vector", bus.vector_o, VN);
        bus.key_valid = 1'b0;
        bus.iako = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        push(9'h055);
        pop();

        // ce held low: strobes must not change anything
        push(9'h0a1);
        push(9'h1a2);
        @(negedge clk);
        ce = 1'b0;
        bus.key_valid = 1'b1; bus.key_code = 8'hee;
        bus.regrd = 1'b1; bus.addr = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0; bus.regrd = 1'b0;
        bus.regwr = 1'b1; bus.addr = 1'b0; bus.data_i = 16'o000100;
        @(negedge clk);
        bus.regwr = 1'b0; bus.regrd = 1'b1; bus.addr = 1'b0;
        @(negedge clk);
        bus.regrd = 1'b0;
        ce = 1'b1;
        chk("ce0 level", 16'(bus.level_o), 16'd2);
        st_read(sv);
        chk("ce0 state", sv, 16'o000200);
        pop();
        pop();

        // Random push/pop traffic against the scoreboard
        for (int i = 0; i < 80; i++) begin
            cycle(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
                  $urandom_range(0, 2) == 0);
            if (i % 10 == 9) st_read(sv);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
